ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Consumes raw PS/2 set-2 bytes from the keyboard receiver (scan_ready/scan_code, cleared via read).
//  Strips E0/F0 prefixes and tracks held state of the game keys LEFT/RIGHT/DOWN/UP/SPACE.
//  Emits one press/release event per real transition into a small valid/ready FIFO for the game FSM.
//  Sits between the keyboard receiver and game control logic, all in the clock50 domain.
// PARAMETERS
//  EVT_DEPTH   4   event FIFO entries (power of 2, >=2)
//  SYNC_STAGES 2   synchroniser flops on scan_ready
// PORTS
//  clock50     in   1  50 MHz system clock
//  reset       in   1  synchronous, active-high
//  scan_ready  in   1  byte-available flag from receiver (stays high until read)
//  scan_code   in   8  received byte, stable while scan_ready=1
//  read        out  1  one-cycle pulse: byte consumed, receiver clears scan_ready
//  key_held    out  5  {SPACE,UP,DOWN,RIGHT,LEFT}, 1 = currently held
//  evt_valid   out  1  FIFO head valid
//  evt_ready   in   1  consumer accepts head when evt_valid&evt_ready
//  evt_key     out  3  key index 0=LEFT 1=RIGHT 2=DOWN 3=UP 4=SPACE
//  evt_press   out  1  1=press, 0=release
//  overflow    out  1  sticky: event dropped because FIFO full
// BEHAVIOUR
//  Reset: read=0, key_held=0, evt_valid=0, evt_key=0, evt_press=0, overflow=0, FSM=IDLE, FIFO empty,
//   sync flops 0, armed=0.
//  Input handshake: scan_ready passes SYNC_STAGES flops; armed sets once synced scan_ready seen 0.
//   Byte accepted on synced rising edge while armed: scan_code registered, read=1 for exactly 1 cycle,
//   armed cleared; next byte only after synced scan_ready returns 0 (no double-consume).
//   scan_ready high at reset release is ignored until it drops.
//  Latency: read asserted 3 cycles after scan_ready first sampled high; key_held/FIFO push 1 cycle after read.
//  Prefix FSM (evaluated on each accepted byte b):
//   IDLE:    b=E0->EXT; b=F0->BRK; else make(b), stay IDLE
//   EXT:     b=F0->EXT_BRK; b=E0->EXT; else make(b)->IDLE
//   BRK:     b=E0/F0->IDLE (protocol error, byte dropped); else break(b)->IDLE
//   EXT_BRK: b=E0/F0->IDLE (protocol error); else break(b)->IDLE
//  Key map on low byte, prefix-independent: 6B LEFT, 74 RIGHT, 72 DOWN, 75 UP, 29 SPACE; others unmapped.
//  make(k): if key_held[k]=0 -> set, push {k,1}; if already 1 (typematic repeat) -> nothing.
//  break(k): if key_held[k]=1 -> clear, push {k,0}; else nothing.
//  Unmapped bytes and AA/FA/EE/FE responses: no state/event change, FSM follows table above.
//  FIFO: push and pop same cycle allowed incl. when full (pop first, no drop); push when full and no pop
//   -> event dropped, key_held still updated, overflow=1 until reset. evt_* driven from head, valid when non-empty.
//  Reset mid-byte or mid-prefix: everything returns to reset values; a pending scan_ready is not re-read
//   until it cycles low.
// STRUCTURE
//  ps2_pkg: key index constants KEY_LEFT..KEY_SPACE, NUM_KEYS=5, codes PS2_EXT=8'hE0, PS2_BRK=8'hF0,
//   make-code constants, FSM state encoding.
//  One sub-module: evt_fifo (sync FIFO, width 4 = {key,press}, depth EVT_DEPTH, full/empty, push/pop).
//  Top holds synchroniser, edge/arm logic, prefix FSM, key_held register, push generation.
// TESTING
//  Bytes 74 -> read pulses once; key_held=00010; one event {1,press}; evt_valid until evt_ready.
//  E0 74, E0 74, E0 F0 74 -> exactly 2 events: {1,1},{1,0}; key_held ends 00000.
//  scan_ready held high 20 cycles with 29 -> single read pulse, single SPACE press; no repeat until it drops.
//  evt_ready=0, press/release 6B,72,75,29,74 (5 presses) -> 4 queued, 5th dropped, overflow=1, key_held=11111.
//  F0 E0 29 -> protocol error: no event, FSM IDLE; following 29 -> SPACE press.
//  reset asserted after E0 F0 with scan_ready high -> all outputs 0; no read until scan_ready low then high.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, prefix FSM states and key map for the PS/2 key decoder
`timescale 1ns/1ps
package ps2_pkg;

  localparam int NUM_KEYS = 5;

  localparam logic [2:0] KEY_LEFT  = 3'd0;
  localparam logic [2:0] KEY_RIGHT = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_UP    = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] MK_LEFT  = 8'h6B;
  localparam logic [7:0] MK_RIGHT = 8'h74;
  localparam logic [7:0] MK_DOWN  = 8'h72;
  localparam logic [7:0] MK_UP    = 8'h75;
  localparam logic [7:0] MK_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } pfx_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_map_t;

  // The low byte alone selects the key, so E0-prefixed arrows map the same as keypad codes.
  function automatic key_map_t map_key(input logic [7:0] b);
    key_map_t m;
    m.hit = 1'b1;
    m.idx = KEY_LEFT;
    case (b)
      MK_LEFT:  m.idx = KEY_LEFT;
      MK_RIGHT: m.idx = KEY_RIGHT;
      MK_DOWN:  m.idx = KEY_DOWN;
      MK_UP:    m.idx = KEY_UP;
      MK_SPACE: m.idx = KEY_SPACE;
      default:  m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_evt_fifo.sv
// rtl/ps2_key_decoder_evt_fifo.sv - small synchronous event FIFO, pop-before-push when full
`timescale 1ns/1ps
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clock50,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 byte consumer, prefix stripping, held-key tracking and event queue
`timescale 1ns/1ps
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int EVT_DEPTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock50,
  input  logic                reset,
  input  logic                scan_ready,
  input  logic [7:0]          scan_code,
  output logic                read,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [2:0]          evt_key,
  output logic                evt_press,
  output logic                overflow
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   ready_sync;
  logic                   armed;
  logic [7:0]             byte_q;
  pfx_state_t             state;
  key_map_t               km;
  logic                   is_pfx, do_make, do_break, key_change;
  logic [3:0]             push_data, head;
  logic                   fifo_full, fifo_empty;

  assign ready_sync = sync_q[SYNC_STAGES-1];

  // fill_q keeps the zeros flushed in by reset from counting as "scan_ready seen low".
  always_ff @(posedge clock50) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
      armed  <= 1'b0;
      read   <= 1'b0;
      byte_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scan_ready};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      read   <= 1'b0;
      if (armed && ready_sync) begin
        read   <= 1'b1;
        byte_q <= scan_code;
        armed  <= 1'b0;
      end else if (fill_q[SYNC_STAGES-1] && !ready_sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign km     = map_key(byte_q);
  assign is_pfx = (byte_q == PS2_EXT) || (byte_q == PS2_BRK);

  always_comb begin
    do_make  = 1'b0;
    do_break = 1'b0;
    case (state)
      ST_IDLE, ST_EXT:    do_make  = !is_pfx;
      ST_BRK, ST_EXT_BRK: do_break = !is_pfx;
      default: ;
    endcase
  end

  // Typematic repeats and releases of keys not held produce no event.
  assign key_change = read && km.hit &&
                      (do_make ? !key_held[km.idx] : (do_break && key_held[km.idx]));
  assign push_data  = {km.idx, do_make};

  always_ff @(posedge clock50) begin
    if (reset) begin
      state    <= ST_IDLE;
      key_held <= '0;
    end else if (read) begin
      if (key_change) key_held[km.idx] <= do_make;
      case (state)
        ST_IDLE: begin
          if (byte_q == PS2_EXT)      state <= ST_EXT;
          else if (byte_q == PS2_BRK) state <= ST_BRK;
        end
        ST_EXT: begin
          if (byte_q == PS2_BRK)      state <= ST_EXT_BRK;
          else if (byte_q != PS2_EXT) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (4)
  ) u_evt_fifo (
    .clock50   (clock50),
    .reset     (reset),
    .push      (key_change),
    .push_data (push_data),
    .pop       (evt_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_key   = evt_valid ? head[3:1] : 3'd0;
  assign evt_press = evt_valid && head[0];

  always_ff @(posedge clock50) begin
    if (reset)                                        overflow <= 1'b0;
    else if (key_change && fifo_full && !evt_ready)   overflow <= 1'b1;
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
`timescale 1ns/1ps
module tb_ps2_key_decoder;
  logic       clock50 = 1'b0;
  logic       reset = 1'b1;
  logic       scan_ready = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       read;
  logic [4:0] key_held;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [2:0] evt_key;
  logic       evt_press;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int read_cnt = 0;
  logic [3:0] evq[$];

  ps2_key_decoder #(.EVT_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clock50    (clock50),
    .reset      (reset),
    .scan_ready (scan_ready),
    .scan_code  (scan_code),
    .read       (read),
    .key_held   (key_held),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_key    (evt_key),
    .evt_press  (evt_press),
    .overflow   (overflow)
  );

  always #10 clock50 = ~clock50;

  always @(negedge clock50) begin
    if (read) read_cnt++;
    if (!reset && evt_valid && evt_ready) evq.push_back({evt_key, evt_press});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock50);
      #1;
    end
  endtask

  // Receiver model: raise scan_ready with the byte, clear it when read pulses.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    @(posedge clock50);
    #1;
    scan_ready = 1'b1;
    scan_code  = b;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock50);
      #1;
      if (read) begin
        got = 1'b1;
        break;
      end
    end
    chk("read_seen", 32'(got), 32'd1);
    scan_ready = 1'b0;
    tick(4);
  endtask

  logic [7:0] presses [5];
  int rc0;

  initial begin
    presses[0] = 8'h6B; presses[1] = 8'h72; presses[2] = 8'h75;
    presses[3] = 8'h29; presses[4] = 8'h74;

    tick(3);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_key_held", 32'(key_held), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_key", 32'(evt_key), 32'd0);
    chk("rst_evt_press", 32'(evt_press), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(4);

    // Single RIGHT make: latency, one read, one queued event held until evt_ready.
    scan_ready = 1'b1;
    scan_code  = 8'h74;
    tick(1); chk("lat_e1_read", 32'(read), 32'd0);
    tick(1); chk("lat_e2_read", 32'(read), 32'd0);
    tick(1); chk("lat_e3_read", 32'(read), 32'd1);
    scan_ready = 1'b0;
    tick(1);
    chk("lat_pulse_len", 32'(read), 32'd0);
    chk("t1_key_held", 32'(key_held), 32'b00010);
    chk("t1_evt_valid", 32'(evt_valid), 32'd1);
    chk("t1_evt_key", 32'(evt_key), 32'd1);
    chk("t1_evt_press", 32'(evt_press), 32'd1);
    tick(3);
    chk("t1_valid_hold", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    chk("t1_popped", 32'(evt_valid), 32'd0);
    chk("t1_read_cnt", 32'(read_cnt), 32'd1);

    send_byte(8'hF0); send_byte(8'h74);
    chk("t1_released", 32'(key_held), 32'd0);
    evq.delete();

    // Extended make, typematic repeat, extended break.
    send_byte(8'hE0); send_byte(8'h74);
    send_byte(8'hE0); send_byte(8'h74);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    chk("t2_evt_count", 32'(evq.size()), 32'd2);
    if (evq.size() == 2) begin
      chk("t2_evt0", 32'(evq[0]), 32'b0011);
      chk("t2_evt1", 32'(evq[1]), 32'b0010);
    end
    chk("t2_key_held", 32'(key_held), 32'd0);
    evq.delete();

    // scan_ready held high: exactly one consume.
    rc0 = read_cnt;
    scan_ready = 1'b1;
    scan_code  = 8'h29;
    tick(20);
    chk("t3_reads", 32'(read_cnt - rc0), 32'd1);
    chk("t3_evt_count", 32'(evq.size()), 32'd1);
    if (evq.size() == 1) chk("t3_evt0", 32'(evq[0]), 32'b1001);
    chk("t3_key_held", 32'(key_held), 32'b10000);
    scan_ready = 1'b0;
    tick(4);
    send_byte(8'hF0); send_byte(8'h29);
    chk("t3_released", 32'(key_held), 32'd0);
    evq.delete();

    // Five presses into a four-entry FIFO with the consumer stalled.
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(presses[i]);
    chk("t4_key_held", 32'(key_held), 32'b11111);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_head_key", 32'(evt_key), 32'd0);
    chk("t4_head_press", 32'(evt_press), 32'd1);
    evt_ready = 1'b1;
    tick(6);
    chk("t4_evt_count", 32'(evq.size()), 32'd4);
    if (evq.size() == 4) begin
      chk("t4_evt0", 32'(evq[0]), 32'b0001);
      chk("t4_evt1", 32'(evq[1]), 32'b0101);
      chk("t4_evt2", 32'(evq[2]), 32'b0111);
      chk("t4_evt3", 32'(evq[3]), 32'b1001);
    end
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hF0);
      send_byte(presses[i]);
    end
    chk("t4_released", 32'(key_held), 32'd0);
    evq.delete();

    // F0 E0 is a protocol error that returns to IDLE.
    send_byte(8'hF0); send_byte(8'hE0);
    chk("t5_no_evt", 32'(evq.size()), 32'd0);
    chk("t5_key_held", 32'(key_held), 32'd0);
    send_byte(8'h29);
    chk("t5_evt_count", 32'(evq.size()), 32'd1);
    if (evq.size() == 1) chk("t5_evt0", 32'(evq[0]), 32'b1001);
    chk("t5_space_held", 32'(key_held), 32'b10000);
    evq.delete();

    // Reset mid-prefix with scan_ready left high.
    send_byte(8'hE0);
    scan_ready = 1'b1;
    scan_code  = 8'hF0;
    tick(5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("t6_key_held", 32'(key_held), 32'd0);
    chk("t6_evt_valid", 32'(evt_valid), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_read", 32'(read), 32'd0);
    rc0 = read_cnt;
    tick(10);
    chk("t6_no_reread", 32'(read_cnt - rc0), 32'd0);
    scan_ready = 1'b0;
    tick(4);
    send_byte(8'h75);
    chk("t6_reads", 32'(read_cnt - rc0), 32'd1);
    chk("t6_up_held", 32'(key_held), 32'b01000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
